// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: byte stream -> little-endian 32-bit words, holds the CPU until loaded.
// Optional trailing checksum byte is compiled in with `define IM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | out of reset, CPU held, waiting for start
// HDR_LO | accept low byte of word count N
// HDR_HI | accept high byte of N, range check
// DATA   | accept payload bytes into the word register
// WRITE  | one-cycle full-word write to instruction memory
// CHK    | accept and compare the checksum byte (checksum build only)
// DONE   | load succeeded, CPU released
// ERR    | load rejected, CPU held
module im_loader #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        im_w_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, DATA, WRITE,
`ifdef IM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam state_t FINAL_ST = CHK;
`else
  localparam state_t FINAL_ST = DONE;
`endif

  state_t              state_q, state_d;
  logic [7:0]          hdr_lo_q, hdr_lo_d;
  logic [15:0]         n_q, n_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-3:0]   word_idx_q, word_idx_d;
  logic                in_ready_q, in_ready_d;
  logic [3:0]          im_w_en_q, im_w_en_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic        accept;
  logic [15:0] n_hdr;
  logic        last_word;

  assign accept    = in_valid && in_ready_q;
  assign n_hdr     = {in_data, hdr_lo_q};
  // Extended compare so the final increment can never alias through a word_idx wrap.
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(n_q);

  always_comb begin
    state_d    = state_q;
    hdr_lo_d   = hdr_lo_q;
    n_d        = n_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      HDR_LO: if (accept) begin
        hdr_lo_d = in_data;
        state_d  = HDR_HI;
      end
      HDR_HI: if (accept) begin
        n_d        = n_hdr;
        byte_cnt_d = 2'd0;
        if (32'(n_hdr) > 32'(MAX_WORDS)) state_d = ERR;
        else if (n_hdr == 16'd0)         state_d = FINAL_ST;
        else                             state_d = DATA;
      end
      DATA: if (accept) begin
        word_d     = {in_data, word_q[31:8]};
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
        sum_d      = sum_q + in_data;
`endif
        if (byte_cnt_q == 2'd3) begin
          state_d    = WRITE;
          im_addr_d  = {word_idx_q, 2'b00};
          im_wdata_d = word_d;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        state_d    = last_word ? FINAL_ST : DATA;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: if (accept) state_d = (in_data == sum_q) ? DONE : ERR;
`endif
      default: ;
    endcase

    // start restarts only from a quiescent state; mid-load it is ignored.
    if (start && (state_q == IDLE || state_q == DONE || state_q == ERR)) begin
      state_d    = HDR_LO;
      word_idx_d = '0;
      byte_cnt_d = 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_d      = 8'd0;
`endif
    end

    in_ready_d = (state_d == HDR_LO) || (state_d == HDR_HI) || (state_d == DATA)
`ifdef IM_LOADER_CHECKSUM_EN
                 || (state_d == CHK)
`endif
                 ;
    im_w_en_d  = (state_d == WRITE) ? 4'b1111 : 4'b0000;
    cpu_hold_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_lo_q   <= 8'd0;
      n_q        <= 16'd0;
      word_q     <= 32'd0;
      byte_cnt_q <= 2'd0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      im_w_en_q  <= 4'b0000;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_lo_q   <= hdr_lo_d;
      n_q        <= n_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      im_w_en_q  <= im_w_en_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign im_w_en  = im_w_en_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader that writes instruction memory for the RV32I single-cycle core. It accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, and writes them to instruction memory through the full-word byte-enable path (`im_w_en = 4'b1111`). It holds the CPU while a load is in progress and releases it only after a successful load.

## Interface
Parameters:
- `ADDR_W`, default 16: width of the instruction-memory byte address.
- `MAX_WORDS`, default 4096: largest accepted word count. Must satisfy 4*MAX_WORDS <= 2^ADDR_W.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a load.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_w_en`  out  4  instruction-memory byte write enables.
- `im_addr`  out  ADDR_W  instruction-memory byte address; always word-aligned.
- `im_wdata`  out  32  instruction-memory write data.
- `cpu_hold`  out  1  when high, the CPU PC and register-file writes are frozen.
- `done`  out  1  load completed successfully.
- `error`  out  1  load rejected.

## Operation
- **Stream format:**
  - Word count N: 2 bytes, low byte first.
  - Payload: 4N bytes. Within each word, byte k lands in bits [8k+7:8k].
  - Checksum: one byte, present only if the checksum feature is compiled in (see Configuration).
- **Handshake:** a byte transfers on a rising edge where `in_valid && in_ready`. An un-accepted byte must be held by the source.
- **States:** IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE, ERR.
- **IDLE** (entered from reset): `cpu_hold=1`, `in_ready=0`. `start` moves to HDR_LO.
- **HDR_LO:** accept a byte, then go to HDR_HI.
- **HDR_HI:** accept a byte, latching N. Then:
  - N > MAX_WORDS goes to ERR, with no writes.
  - N == 0 goes to CHK if enabled, else DONE.
  - Otherwise go to DATA.
- **DATA:** accept bytes into the word register. After the 4th byte, go to WRITE.
- **WRITE:** lasts one cycle.
  - Outputs: `im_w_en=4'b1111`, `im_addr=word_idx*4`, `im_wdata` = the assembled word.
  - `word_idx` increments.
  - If the incremented count equals N, go to CHK if enabled, else DONE. Otherwise return to DATA.
- **CHK:** accept one byte.
  - Byte equal to the 8-bit running sum (mod 256) of all payload bytes goes to DONE.
  - Any other byte goes to ERR.
  - Memory writes already performed are not undone.
- **DONE:** `done=1`, `cpu_hold=0`.
- **ERR:** `error=1`, `cpu_hold=1`.
- **`in_ready`:** 1 only in HDR_LO, HDR_HI, DATA and CHK.
- **`start` handling:**
  - In IDLE, DONE or ERR: next state is HDR_LO. `word_idx`, checksum, `done` and `error` clear, and `cpu_hold` rises.
  - In any other state, `start` is ignored.
- **Outputs outside WRITE:** `im_w_en=0`. `im_addr` and `im_wdata` hold their last values.

## Timing
- **Reset values:** state IDLE, `in_ready=0`, `im_w_en=0`, `im_addr=0`, `im_wdata=0`, `cpu_hold=1`, `done=0`, `error=0`. Internal counters and the checksum are 0.
- All outputs are registered-state decodes; there are no combinational paths from inputs to outputs.
- **Write latency:** WRITE is the cycle immediately after the edge that accepts the 4th byte of a word.
- **Throughput:** at most one word per 5 cycles. `in_ready=0` during WRITE applies backpressure.
- **Completion:** `done` or `error` asserts in the cycle after the final WRITE or CHK edge, and stays asserted until `start` or reset.
- **Reset mid-load:** all outputs return to reset values immediately (asynchronous). An in-flight WRITE is suppressed and partial words are discarded.
- `word_idx` is ADDR_W-2 bits wide. The MAX_WORDS check prevents wrap-around.

## Configuration
- Macro `IM_LOADER_CHECKSUM_EN`.
- **Defined:** the CHK state exists. One trailing sum byte is required, and a mismatch goes to ERR.
- **Undefined:** the CHK state and the sum register are removed. The final WRITE, or N == 0 after HDR_HI, goes directly to DONE. No trailing byte is consumed.

## Test plan
1. **Basic two-word load (checksum enabled).** Reset, pulse `start`, stream `02 00 13 00 00 00 93 00 10 00 B6`.
   - Expect two single-cycle writes: addr 0x0 / 0x00000013, then addr 0x4 / 0x00100093, each with `im_w_en=4'b1111`.
   - Then `done=1`, `cpu_hold=0`, `error=0`.
2. **Bad checksum.** Same stream with final byte `B7`.
   - Both writes still occur.
   - Then `error=1`, `cpu_hold=1`, `done=0`.
3. **Oversize header.** `MAX_WORDS=4096`, header `01 10` (N=4097).
   - Expect ERR right after HDR_HI, with `im_w_en` never asserted.
   - A subsequent `start` followed by a valid stream loads correctly.
4. **Empty program.** Header `00 00`.
   - Checksum enabled: trailing `00` is required, then DONE.
   - Checksum disabled: DONE immediately after HDR_HI.
   - No writes in either case.
5. **Backpressure and gaps.** Test 1 stream with random `in_valid` gaps.
   - Verify a byte presented during WRITE is not consumed until `in_ready` returns.
   - Results must be identical to test 1.
6. **Reset mid-load.** Drop `rst_n` after the 6th accepted byte.
   - All outputs go to reset values asynchronously, and no write occurs.
   - After release, `start` followed by the test 1 stream reproduces test 1.
